// File: rtl/i2s_pkg.sv
// Shared I2S definitions: controller states and default slot geometry,
// used by both the playback transmitter and the capture receiver.
package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } i2s_state_t;

   localparam int I2S_SAMPLE_WIDTH = 24;
   localparam int I2S_SLOT_WIDTH   = 32;

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: toggles sck every SCK_DIV clk while en=1 and flags the
// clk on which sck goes 1->0, so the caller can update on that same edge.
module i2s_sck_gen #(
   parameter int SCK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sck,
   output logic fall
);

   localparam int CW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          tick;

   assign tick = en && (cnt == CW'(SCK_DIV - 1));
   assign fall = tick && sck;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (tick) begin
         cnt <= '0;
         sck <= ~sck;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter (Philips format): fetches alternating left/right
// words from a FIFO read port and serialises them MSB-first on SD.
module i2s_transmitter
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
   parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
   parameter int SCK_DIV      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable_i,
   input  logic                    fifo_empty_i,
   output logic                    fifo_rd_en_o,
   input  logic [SAMPLE_WIDTH-1:0] fifo_data_i,
   output logic                    i2s_sck_o,
   output logic                    i2s_ws_o,
   output logic                    i2s_sd_o,
   output logic                    underrun_o,
   output logic                    busy_o
);

   localparam int FRAME = 2 * SLOT_WIDTH;
   localparam int PW    = $clog2(FRAME);

   localparam logic [PW-1:0] POS_LAST    = PW'(FRAME - 1);
   localparam logic [PW-1:0] POS_SLOT    = PW'(SLOT_WIDTH);
   localparam logic [PW-1:0] POS_L_LOAD  = PW'(1);
   localparam logic [PW-1:0] POS_R_LOAD  = PW'(SLOT_WIDTH + 1);
   localparam logic [PW-1:0] POS_R_FETCH = PW'(2);
   localparam logic [PW-1:0] POS_L_FETCH = PW'(SLOT_WIDTH + 2);

   i2s_state_t              state, state_nxt;
   logic [PW-1:0]           pos, pos_nxt;
   logic [SAMPLE_WIDTH-1:0] hold;
   logic [SLOT_WIDTH-1:0]   sr;
   logic                    ws;
   logic                    cap_pending;
   logic                    stop_pending;
   logic                    sck_fall;
   logic                    fetch;

   i2s_sck_gen #(
      .SCK_DIV(SCK_DIV)
   ) u_sck_gen (
      .clk (clk),
      .rst (rst),
      .en  (state == RUN),
      .sck (i2s_sck_o),
      .fall(sck_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      pos_nxt   = (pos == POS_LAST) ? '0 : pos + PW'(1);
      fetch     = 1'b0;
      unique case (state)
         IDLE:  if (enable_i) state_nxt = PRIME;
         PRIME: begin
            state_nxt = RUN;
            fetch     = 1'b1;
         end
         RUN: begin
            if (sck_fall && (pos == POS_LAST) && stop_pending) state_nxt = IDLE;
            fetch = sck_fall && ((pos_nxt == POS_R_FETCH) ||
                                 ((pos_nxt == POS_L_FETCH) && enable_i));
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos          <= '0;
         hold         <= '0;
         sr           <= '0;
         ws           <= 1'b0;
         cap_pending  <= 1'b0;
         stop_pending <= 1'b0;
         fifo_rd_en_o <= 1'b0;
         underrun_o   <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         busy_o       <= (state_nxt != IDLE);
         fifo_rd_en_o <= 1'b0;
         underrun_o   <= 1'b0;
         // FIFO data is valid the clk after the strobe, so capture one clk later.
         cap_pending  <= fifo_rd_en_o;
         if (cap_pending) hold <= fifo_data_i;

         if (fetch) begin
            if (!fifo_empty_i) begin
               fifo_rd_en_o <= 1'b1;
            end else begin
               underrun_o <= 1'b1;
               hold       <= '0;
            end
         end

         if (state == PRIME) begin
            // Parked on the last position so the first fall event wraps to 0.
            pos          <= POS_LAST;
            ws           <= 1'b0;
            sr           <= '0;
            stop_pending <= 1'b0;
         end else if (state == RUN && sck_fall) begin
            if (state_nxt == IDLE) begin
               pos          <= '0;
               ws           <= 1'b0;
               sr           <= '0;
               stop_pending <= 1'b0;
            end else begin
               pos <= pos_nxt;
               ws  <= (pos_nxt >= POS_SLOT);
               if ((pos_nxt == POS_L_LOAD) || (pos_nxt == POS_R_LOAD))
                  sr <= SLOT_WIDTH'(hold) << (SLOT_WIDTH - SAMPLE_WIDTH);
               else
                  sr <= sr << 1;
               if ((pos_nxt == POS_L_FETCH) && !enable_i) stop_pending <= 1'b1;
            end
         end
      end
   end

   assign i2s_ws_o = ws;
   assign i2s_sd_o = sr[SLOT_WIDTH-1];

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: a 24-bit instance for the main
// scenarios and a 32-bit instance for full-width LSB placement.
module tb_i2s_transmitter;

   localparam int SW   = 24;
   localparam int SLOT = 32;
   localparam int DIV  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 24-bit instance and its FIFO model
   logic          en = 1'b0;
   logic          empty;
   logic          rd_en;
   logic [SW-1:0] fifo_data = '0;
   logic          sck, ws, sd, und, busy;
   logic [SW-1:0] mem [16];
   int            wr_ptr = 0;
   int            rd_ptr = 0;

   // 32-bit instance and its FIFO model
   logic        en32 = 1'b0;
   logic        empty32;
   logic        rd32;
   logic [31:0] fifo_data32 = '0;
   logic        sck32, ws32, sd32, und32, busy32;
   logic [31:0] mem32 [16];
   int          wr32 = 0;
   int          rdp32 = 0;

   i2s_transmitter #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .SCK_DIV(DIV)) u_dut (
      .clk(clk), .rst(rst), .enable_i(en), .fifo_empty_i(empty), .fifo_rd_en_o(rd_en),
      .fifo_data_i(fifo_data), .i2s_sck_o(sck), .i2s_ws_o(ws), .i2s_sd_o(sd),
      .underrun_o(und), .busy_o(busy)
   );

   i2s_transmitter #(.SAMPLE_WIDTH(32), .SLOT_WIDTH(SLOT), .SCK_DIV(DIV)) u_dut32 (
      .clk(clk), .rst(rst), .enable_i(en32), .fifo_empty_i(empty32), .fifo_rd_en_o(rd32),
      .fifo_data_i(fifo_data32), .i2s_sck_o(sck32), .i2s_ws_o(ws32), .i2s_sd_o(sd32),
      .underrun_o(und32), .busy_o(busy32)
   );

   assign empty   = (wr_ptr == rd_ptr);
   assign empty32 = (wr32 == rdp32);

   // FIFO read side: one-clk read latency
   always @(posedge clk) begin
      if (rd_en && !empty) begin
         fifo_data <= mem[rd_ptr % 16];
         rd_ptr    <= rd_ptr + 1;
      end
      if (rd32 && !empty32) begin
         fifo_data32 <= mem32[rdp32 % 16];
         rdp32       <= rdp32 + 1;
      end
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Scoreboards: decoded 24-bit slot words, and {ws,sd} at slot offsets 0/1 of the 32-bit unit
   logic [SW-1:0] exp_q[$];
   logic [1:0]    exp32_q[$];

   int rd_cnt = 0, und_cnt = 0;
   int rise_cnt = 0, mon_pos = -1, mon_frame = -1, ws_err = 0;
   int rise32 = 0, pos32 = -1, frame32 = -1;
   logic sck_prev = 1'b0, sck32_prev = 1'b0;
   logic [31:0] slot_bits = '0;

   // Monitor: SD/WS sampled on SCK rising edges; rise 0 precedes the first fall (pos 0)
   always @(negedge clk) begin
      logic [63:0] act;
      logic [SW-1:0] e;
      int p;
      if (rd_en) check("rd_en_while_empty", 64'(empty), 64'd0);
      if (rd32) check("rd32_while_empty", 64'(empty32), 64'd0);
      if (rd_en) rd_cnt++;
      if (und) und_cnt++;

      if (!busy) begin
         rise_cnt = 0; mon_pos = -1; mon_frame = -1; ws_err = 0;
      end else if (sck && !sck_prev) begin
         if (rise_cnt >= 1) begin
            p = (rise_cnt - 1) % (2 * SLOT);
            mon_pos = p;
            mon_frame = (rise_cnt - 1) / (2 * SLOT);
            if (ws !== (p >= SLOT)) ws_err++;
            slot_bits[31 - (p % SLOT)] = sd;
            if ((p % SLOT) == SLOT - 1) begin
               act = {24'd0, 8'(ws_err), slot_bits[6:0], slot_bits[31], slot_bits[30:7]};
               if (exp_q.size() == 0) begin
                  check("slot_unexpected", act, 64'hDEAD_0000_0000_0000);
               end else begin
                  e = exp_q.pop_front();
                  check("slot", act, 64'(e));
               end
               ws_err = 0;
            end
         end
         rise_cnt++;
      end
      sck_prev = sck;

      if (!busy32) begin
         rise32 = 0; pos32 = -1; frame32 = -1;
      end else if (sck32 && !sck32_prev) begin
         if (rise32 >= 1) begin
            p = (rise32 - 1) % (2 * SLOT);
            pos32 = p;
            frame32 = (rise32 - 1) / (2 * SLOT);
            if ((p % SLOT) <= 1) begin
               if (exp32_q.size() == 0) check("edge32_unexpected", {ws32, sd32}, 64'hDEAD);
               else check("edge32_ws_sd", {ws32, sd32}, 64'(exp32_q.pop_front()));
            end
         end
         rise32++;
      end
      sck32_prev = sck32;
   end

   task automatic push(input logic [SW-1:0] w);
      mem[wr_ptr % 16] = w;
      wr_ptr++;
   endtask

   task automatic push32(input logic [31:0] w);
      mem32[wr32 % 16] = w;
      wr32++;
   endtask

   task automatic wait_pos(input bit sel32, input int f, input int p, input string name);
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (sel32 ? (frame32 == f && pos32 == p) : (mon_frame == f && mon_pos == p)) return;
      end
      check({name, "_pos_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input bit sel32, input string name);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (!(sel32 ? busy32 : busy)) return;
      end
      check({name, "_idle_timeout"}, 64'd0, 64'd1);
   endtask

   int rd0, u0;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sck", 64'(sck), 64'd0);
      check("rst_ws", 64'(ws), 64'd0);
      check("rst_sd", 64'(sd), 64'd0);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      check("rst_underrun", 64'(und), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Basic frame: two words, stop requested early in frame 0
      push(24'hA5F00F); push(24'h123456);
      exp_q.push_back(24'hA5F00F); exp_q.push_back(24'h123456);
      rd0 = rd_cnt; u0 = und_cnt;
      en = 1'b1;
      wait_pos(0, 0, 10, "t1");
      en = 1'b0;
      wait_idle(0, "t1");
      check("t1_reads", 64'(rd_cnt - rd0), 64'd2);
      check("t1_underruns", 64'(und_cnt - u0), 64'd0);
      check("t1_sb_drained", 64'(exp_q.size()), 64'd0);
      check("t1_idle_lines", {sck, ws, sd}, 64'd0);

      // Empty FIFO: zero slots, an underrun per fetch, no reads
      exp_q.push_back(24'h0); exp_q.push_back(24'h0);
      rd0 = rd_cnt; u0 = und_cnt;
      en = 1'b1;
      wait_pos(0, 0, 10, "t2");
      en = 1'b0;
      wait_idle(0, "t2");
      check("t2_reads", 64'(rd_cnt - rd0), 64'd0);
      check("t2_underruns", 64'(und_cnt - u0), 64'd2);
      check("t2_sb_drained", 64'(exp_q.size()), 64'd0);

      // Four words, stop at pos 10: one frame, two reads, two words left behind
      push(24'h111111); push(24'h222222); push(24'h333333); push(24'h444444);
      exp_q.push_back(24'h111111); exp_q.push_back(24'h222222);
      rd0 = rd_cnt;
      en = 1'b1;
      wait_pos(0, 0, 10, "t3");
      en = 1'b0;
      wait_idle(0, "t3");
      check("t3_reads", 64'(rd_cnt - rd0), 64'd2);
      check("t3_fifo_left", 64'(wr_ptr - rd_ptr), 64'd2);
      check("t3_sb_drained", 64'(exp_q.size()), 64'd0);
      wr_ptr = rd_ptr;

      // Reset at pos 40 aborts the right slot; restart is clean
      push(24'h654321); push(24'hFEDCBA);
      exp_q.push_back(24'h654321);
      en = 1'b1;
      wait_pos(0, 0, 40, "t5");
      rst = 1'b1; en = 1'b0;
      @(posedge clk); @(negedge clk);
      check("t5_rst_lines", {sck, ws, sd}, 64'd0);
      check("t5_rst_strobes", {rd_en, und}, 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      check("t5_sb_left_only", 64'(exp_q.size()), 64'd0);
      push(24'h0ABCDE); push(24'h13579B);
      exp_q.push_back(24'h0ABCDE); exp_q.push_back(24'h13579B);
      rd0 = rd_cnt;
      en = 1'b1;
      wait_pos(0, 0, 10, "t5b");
      en = 1'b0;
      wait_idle(0, "t5b");
      check("t5_reads", 64'(rd_cnt - rd0), 64'd2);
      check("t5_sb_drained", 64'(exp_q.size()), 64'd0);

      // FIFO runs dry in frame 1 (right slot), refilled before frame 2
      push(24'hC0FFEE); push(24'h00BEEF); push(24'h7E57ED);
      exp_q.push_back(24'hC0FFEE); exp_q.push_back(24'h00BEEF);
      exp_q.push_back(24'h7E57ED); exp_q.push_back(24'h000000);
      exp_q.push_back(24'hABCDEF); exp_q.push_back(24'h000001);
      rd0 = rd_cnt; u0 = und_cnt;
      en = 1'b1;
      wait_pos(0, 1, 10, "t6");
      push(24'hABCDEF); push(24'h000001);
      wait_pos(0, 2, 10, "t6b");
      en = 1'b0;
      wait_idle(0, "t6");
      check("t6_reads", 64'(rd_cnt - rd0), 64'd5);
      check("t6_underruns", 64'(und_cnt - u0), 64'd1);
      check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

      // Full-width samples: LSB sits on the WS-change SCK cycle
      push32(32'h8000_0001); push32(32'h0000_0001); push32(32'h8000_0000); push32(32'h0000_0001);
      exp32_q = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
      en32 = 1'b1;
      wait_pos(1, 1, 10, "t4");
      en32 = 1'b0;
      wait_idle(1, "t4");
      check("t4_sb_drained", 64'(exp32_q.size()), 64'd0);
      check("t4_fifo_left", 64'(wr32 - rdp32), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
